// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory read port plus the decode-side valid/ready head port.
// master = fetch unit, slave = memory/decode side.
interface ifu_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc8;
  logic [31:0]       out_instr;
  logic              out_adel;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_pc8,
    output out_instr,
    output out_adel,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_pc8,
    input  out_instr,
    input  out_adel,
    input  count
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Fetch unit: owns the fetch PC and buffers {pc, instr} in a DEPTH-entry FIFO towards decode.
// Optional misaligned-fetch detection with halt is enabled by defining IFU_ALIGN_CHK_EN.
module ifu_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(32'h0000_4180)
) (
  input  logic              clk,
  input  logic              reset,
  ifu_fetch_queue_if.master bus,
  input  logic              fetch_stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              int_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fpc_reg, fpc_next;
  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic              adel_mem  [DEPTH];
  logic [DEPTH-1:0]  wr_en;

  logic              pop, push, flush, full, halted;
  logic              wr_adel;
  logic [31:0]       wr_instr;
  logic [ADDR_W-1:0] redirect_ld, epc_ld;

`ifdef IFU_ALIGN_CHK_EN
  logic halted_reg, halted_next;
  logic misalign;

  assign misalign    = (fpc_reg[1:0] != 2'b00);
  assign halted      = halted_reg;
  assign wr_adel     = misalign;
  assign redirect_ld = redirect_pc;
  assign epc_ld      = epc;

  // Halt on a faulting push; any control-flow change restarts fetch.
  always_comb begin
    halted_next = halted_reg;
    if (flush)
      halted_next = 1'b0;
    else if (push && misalign)
      halted_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      halted_reg <= 1'b0;
    else
      halted_reg <= halted_next;
  end
`else
  // Targets are word-aligned on load, so the low target bits never reach fpc.
  logic unused_low_bits;
  assign unused_low_bits = ^{redirect_pc[1:0], epc[1:0]};

  assign halted      = 1'b0;
  assign wr_adel     = 1'b0;
  assign redirect_ld = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign epc_ld      = {epc[ADDR_W-1:2], 2'b00};
`endif

  assign wr_instr = wr_adel ? 32'h0 : bus.imem_rdata;

  assign bus.out_valid = (count_reg != '0);
  assign full          = (count_reg == CNT_W'(DEPTH));
  assign pop           = bus.out_valid & bus.out_ready;
  assign flush         = int_req | eret | redirect;
  assign push          = ~flush & ~fetch_stall & ~halted & (~full | pop);

  // A redirect-cycle pop is the delay slot; it is consumed, everything younger is flushed.
  always_comb begin
    fpc_next   = fpc_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (int_req) begin
      fpc_next   = EXC_PC;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else if (eret) begin
      fpc_next   = epc_ld;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else if (redirect) begin
      fpc_next   = redirect_ld;
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        fpc_next  = fpc_reg + ADDR_W'(4);
        tail_next = tail_reg + PTR_W'(1);
      end
      if (pop)
        head_next = head_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_reg   <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      fpc_reg   <= fpc_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (tail_reg == PTR_W'(gi));
  end

  // Entry storage carries no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        pc_mem[i]    <= fpc_reg;
        instr_mem[i] <= wr_instr;
        adel_mem[i]  <= wr_adel;
      end
    end
  end

  assign bus.imem_addr = fpc_reg;
  assign bus.count     = count_reg;
  assign bus.out_pc    = bus.out_valid ? pc_mem[head_reg] : '0;
  assign bus.out_pc8   = bus.out_valid ? pc_mem[head_reg] + ADDR_W'(8) : '0;
  assign bus.out_instr = bus.out_valid ? instr_mem[head_reg] : 32'h0;
  assign bus.out_adel  = bus.out_valid & adel_mem[head_reg];

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a head-entry scoreboard; memory word = its address.
// Build with IFU_ALIGN_CHK_EN defined to also exercise the misaligned-fetch halt.
module tb_ifu_fetch_queue;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_stall, redirect, int_req, eret;
  logic [31:0] redirect_pc, epc;

  ifu_fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
  assign bus.imem_rdata = bus.imem_addr;

  ifu_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .fetch_stall (fetch_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .int_req     (int_req),
    .eret        (eret),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_fpc;
  int          m_count;
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_target(input logic [31:0] t);
`ifdef IFU_ALIGN_CHK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  // One clock: check DUT against the model, advance the model, then step to the next negedge.
  task automatic cyc();
    bit   pop, push, misal;
    ent_t e;
    if (!reset) begin
      chk("valid", 32'(bus.out_valid), 32'(m_count != 0));
      chk("count", 32'(bus.count), 32'(m_count));
      chk("imem_addr", bus.imem_addr, m_fpc);
      if (m_count != 0 && bus.out_ready) begin
        chk("sb_pc", bus.out_pc, exp_q[0].pc);
        chk("sb_pc8", bus.out_pc8, exp_q[0].pc + 32'd8);
        chk("sb_instr", bus.out_instr, exp_q[0].instr);
        chk("sb_adel", 32'(bus.out_adel), 32'(exp_q[0].adel));
        $display("pop pc=%h instr=%h adel=%0d", bus.out_pc, bus.out_instr, bus.out_adel);
      end
    end
    if (reset) begin
      m_fpc = 32'h0000_3000; m_count = 0; m_halted = 0; exp_q.delete();
    end else if (int_req || eret || redirect) begin
      exp_q.delete(); m_count = 0; m_halted = 0;
      m_fpc = int_req ? 32'h0000_4180 : (eret ? ld_target(epc) : ld_target(redirect_pc));
    end else begin
      pop  = (m_count != 0) && bus.out_ready;
      push = !fetch_stall && !m_halted && (m_count < DEPTH || pop);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
`ifdef IFU_ALIGN_CHK_EN
        misal = (m_fpc[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        e.pc = m_fpc; e.instr = misal ? 32'h0 : m_fpc; e.adel = misal;
        exp_q.push_back(e);
        if (misal) m_halted = 1;
        m_fpc = m_fpc + 32'd4;
      end
      m_count = m_count + int'(push) - int'(pop);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; fetch_stall = 1'b0; redirect = 1'b0; int_req = 1'b0; eret = 1'b0;
    redirect_pc = 32'h0; epc = 32'h0; bus.out_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_pc8", bus.out_pc8, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_adel", 32'(bus.out_adel), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_3000);

    // Streaming with out_ready=1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_pc", bus.out_pc, 32'h0000_3000 + 32'(4 * i));
      chk("t1_pc8", bus.out_pc8, 32'h0000_3008 + 32'(4 * i));
    end

    // Fill to full with consumer stalled, then pop+push at full
    bus.out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_3000;
    cyc();
    redirect = 1'b0;
    chk("t2_flush_count", 32'(bus.count), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      int k;
      cyc();
      k = (i < 4) ? i : 4;
      chk("t2_count", 32'(bus.count), 32'(k));
      chk("t2_addr", bus.imem_addr, 32'h0000_3000 + 32'(4 * k));
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("t2_full_count", 32'(bus.count), 32'd4);
    chk("t2_full_pc", bus.out_pc, 32'h0000_3004);
    chk("t2_full_addr", bus.imem_addr, 32'h0000_3014);

    // Delay-slot pop at 0x3004 with redirect
    redirect = 1'b1; redirect_pc = 32'h0000_3100;
    cyc();
    redirect = 1'b0;
    chk("t3_count", 32'(bus.count), 32'd0);
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("t3_pc", bus.out_pc, 32'h0000_3100);

    // int_req beats redirect and stall; later eret
    fetch_stall = 1'b1; int_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3300;
    cyc();
    fetch_stall = 1'b0; int_req = 1'b0; redirect = 1'b0;
    chk("t4_addr", bus.imem_addr, 32'h0000_4180);
    chk("t4_count", 32'(bus.count), 32'd0);
    cyc(); cyc();
    chk("t4_hpc", bus.out_pc, 32'h0000_4184);
    eret = 1'b1; epc = 32'h0000_3020;
    cyc();
    eret = 1'b0;
    chk("t4_eret_addr", bus.imem_addr, 32'h0000_3020);
    cyc();
    chk("t4_eret_pc", bus.out_pc, 32'h0000_3020);

    // Stall drains the FIFO, PC holds, then resumes
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_count", 32'(bus.count), 32'd0);
      chk("t5_addr", bus.imem_addr, 32'h0000_3024);
    end
    fetch_stall = 1'b0;
    cyc();
    chk("t5_resume_addr", bus.imem_addr, 32'h0000_3028);
    cyc();
    chk("t5_resume_pc", bus.out_pc, 32'h0000_3028);

    // Address wrap at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("wrap_pc8_a", bus.out_pc8, 32'h0000_0000);
    cyc();
    chk("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc8_b", bus.out_pc8, 32'h0000_0004);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

`ifdef IFU_ALIGN_CHK_EN
    // Misaligned target: one faulting entry, then halted until redirect
    redirect = 1'b1; redirect_pc = 32'h0000_3102;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t6_adel", 32'(bus.out_adel), 32'd1);
    chk("t6_instr", bus.out_instr, 32'h0);
    chk("t6_pc", bus.out_pc, 32'h0000_3102);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_halt_valid", 32'(bus.out_valid), 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_3200;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t6_resume_pc", bus.out_pc, 32'h0000_3200);
    chk("t6_resume_adel", 32'(bus.out_adel), 32'd0);
`else
    // Misaligned eret target is word-aligned on load
    eret = 1'b1; epc = 32'h0000_3042;
    cyc();
    eret = 1'b0;
    chk("al_addr", bus.imem_addr, 32'h0000_3040);
    cyc();
    chk("al_pc", bus.out_pc, 32'h0000_3040);
    chk("al_adel", 32'(bus.out_adel), 32'd0);
`endif

    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
